uart_tx_stream: RTL

- UART transmitter that drains a byte stream from the valid/ready ring buffer output side and serialises each byte onto the TX line.
- Frame format: start bit, DATA_WIDTH data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Sits between the TX ring buffer and the FPGA TX pin. Accepts one byte per frame and applies backpressure through s_ready while a frame is in flight.

---
 rtl/uart_tx_stream.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: UART transmitter draining a valid/ready byte stream onto a registered TX line
module uart_tx_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [3:0]           DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]           STOP_LAST = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_MODE < 0 ||
        PARITY_MODE > 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_param_check
        $error("uart_tx_stream: illegal parameter combination");
    end

    logic [2:0]            state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [3:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  bit_end;
    logic                  handshake;

    assign s_ready   = (state == IDLE) && !rst;
    assign busy      = state != IDLE;
    assign bit_end   = cnt == CNT_LAST;
    assign handshake = s_valid && s_ready;
    assign tx_done   = (state == STOP) && bit_end && (bit_idx == STOP_LAST);

    // Frame sequencer: tx is loaded with the next bit value on every state entry so the line stays glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        shreg   <= s_data;
                        par_bit <= (^s_data) ^ (PARITY_MODE == 2);
                        state   <= START;
                        cnt     <= '0;
                        tx      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == DATA_LAST) begin
                            if (PARITY_MODE != 0) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state   <= STOP;
                                bit_idx <= '0;
                                tx      <= 1'b1;
                            end
                        end else begin
                            tx <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            state   <= IDLE;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
